// File: rtl/multi_counter_sram_pkg.sv
// Shared definitions for the SRAM-backed counter bank.
//   op_t        : 3-bit command opcode
//   state_t     : zero-sweep / run state
//   OP_WRITE_B  : attribute bit set when an opcode writes the counter back
//   OP_OUTPUT_B : attribute bit set when an opcode produces a response
//   op_attr()   : opcode -> attribute bits
package multi_counter_sram_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INIT = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_QRY  = 3'd4,
    OP_FADD = 3'd5
  } op_t;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int OP_WRITE_B  = 0;
  localparam int OP_OUTPUT_B = 1;

  // Undefined encodings behave as NOP: no write, no response.
  function automatic logic [1:0] op_attr(op_t op);
    logic [1:0] a;
    case (op)
      OP_INIT: a = 2'b01;
      OP_ADD:  a = 2'b01;
      OP_SUB:  a = 2'b01;
      OP_QRY:  a = 2'b10;
      OP_FADD: a = 2'b11;
      default: a = 2'b00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/multi_counter_sram_alu.sv
// Combinational counter arithmetic.
//   op  : opcode of the executing command
//   a   : current counter value (after forwarding)
//   b   : command operand
//   res : new counter value (wrapped or clamped according to SAT)
//   ovf : carry out of ADD/FADD or borrow out of SUB
module multi_counter_sram_alu
  import multi_counter_sram_pkg::*;
#(
  parameter int W   = 32,
  parameter int SAT = 0
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         ovf
);

  logic [W:0] sum;
  logic [W:0] diff;

  // Bit W of the widened result is the carry (add) or borrow (sub).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select result and overflow flag by opcode.
  always_comb begin
    res = a;
    ovf = 1'b0;
    case (op)
      OP_INIT: begin
        res = b;
        ovf = 1'b0;
      end
      OP_ADD, OP_FADD: begin
        ovf = sum[W];
        if ((SAT != 0) && sum[W]) begin
          res = {W{1'b1}};
        end else begin
          res = sum[W-1:0];
        end
      end
      OP_SUB: begin
        ovf = diff[W];
        if ((SAT != 0) && diff[W]) begin
          res = {W{1'b0}};
        end else begin
          res = diff[W-1:0];
        end
      end
      default: begin
        res = a;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_counter_sram.sv
// Bank of N W-bit counters held in a simple dual-port SRAM, driven by a
// four-stage command pipeline (S0 register, S1 read, S2 execute, S3 write
// back + output register). After every reset the SRAM is swept to zero
// while busy_r is high; commands presented during the sweep are dropped.
//   clk, rst           : clock, synchronous active-high reset
//   cmd_vld/cmd_rdy    : command handshake (cmd_rdy = ~busy_r)
//   cmd_op/id/dat      : opcode, counter index, operand
//   busy_r             : zero-sweep in progress
//   rsp_vld_r/id/dat   : response pulse for QRY / FADD
//   evt_vld_r/evt_id_r : carry/borrow event pulse
module multi_counter_sram
  import multi_counter_sram_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 32,
  parameter int SAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [2:0]           cmd_op,
  input  logic [$clog2(N)-1:0] cmd_id,
  input  logic [W-1:0]         cmd_dat,
  output logic                 busy_r,
  output logic                 rsp_vld_r,
  output logic [$clog2(N)-1:0] rsp_id_r,
  output logic [W-1:0]         rsp_dat_r,
  output logic                 evt_vld_r,
  output logic [$clog2(N)-1:0] evt_id_r
);

  localparam int IW = $clog2(N);

  typedef struct packed {
    op_t           op;
    logic [IW-1:0] id;
    logic [W-1:0]  dat;
  } ucode_t;

  state_t        state;
  logic [IW-1:0] sweep_cnt;

  logic          s0_vld, s1_vld, s2_vld, s3_vld;
  ucode_t        s0_uc, s1_uc, s2_uc;
  logic [W-1:0]  s2_opv;
  op_t           s3_op;
  logic [IW-1:0] s3_id;
  logic [W-1:0]  s3_opv, s3_res;
  logic          s3_ovf;
  logic          s4_wr;
  logic [IW-1:0] s4_id;
  logic [W-1:0]  s4_res;

  logic [1:0]    s2_attr, s3_attr;
  logic          s2_wr, s3_wr;
  logic [W-1:0]  s1_fwd, s2_opv_f;
  logic [W-1:0]  alu_res;
  logic          alu_ovf;

  logic          mem_re, mem_we;
  logic [IW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic [W-1:0]  mem [N];

  assign cmd_rdy = ~busy_r;

  assign s2_attr = op_attr(s2_uc.op);
  assign s3_attr = op_attr(s3_op);
  assign s2_wr   = s2_vld & s2_attr[OP_WRITE_B];
  assign s3_wr   = s3_vld & s3_attr[OP_WRITE_B];

  // An S0 read that hits the address S3 is writing this edge is skipped; the
  // value is picked up from S4 one cycle later, so the SRAM never sees a
  // same-address read and write together.
  assign mem_re = s0_vld & ~(s3_wr & (s3_id == s0_uc.id));

  // Write port: zeros during the sweep, S3 write-back in run. A reset edge
  // blocks the write so a killed command leaves no trace.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s3_id;
    mem_wdata = s3_res;
    if (state == ST_SWEEP) begin
      mem_we    = ~rst;
      mem_waddr = sweep_cnt;
      mem_wdata = {W{1'b0}};
    end else begin
      mem_we    = ~rst & s3_wr;
      mem_waddr = s3_id;
      mem_wdata = s3_res;
    end
  end

  // Dual-port counter storage; contents are established by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_re) begin
      mem_rdata <= mem[s0_uc.id];
    end
  end

  // S1 operand: youngest older writer wins (S2 result, then S3, then S4),
  // falling back to the SRAM read data.
  always_comb begin
    s1_fwd = mem_rdata;
    if (s2_wr && (s2_uc.id == s1_uc.id)) begin
      s1_fwd = alu_res;
    end else if (s3_wr && (s3_id == s1_uc.id)) begin
      s1_fwd = s3_res;
    end else if (s4_wr && (s4_id == s1_uc.id)) begin
      s1_fwd = s4_res;
    end else begin
      s1_fwd = mem_rdata;
    end
  end

  // S2 operand refresh from the two stages ahead of it.
  always_comb begin
    s2_opv_f = s2_opv;
    if (s3_wr && (s3_id == s2_uc.id)) begin
      s2_opv_f = s3_res;
    end else if (s4_wr && (s4_id == s2_uc.id)) begin
      s2_opv_f = s4_res;
    end else begin
      s2_opv_f = s2_opv;
    end
  end

  multi_counter_sram_alu #(
    .W   (W),
    .SAT (SAT)
  ) u_alu (
    .op  (s2_uc.op),
    .a   (s2_opv_f),
    .b   (s2_uc.dat),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  // Zero-sweep FSM: SWEEP walks every address once, then RUN until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SWEEP;
      sweep_cnt <= {IW{1'b0}};
      busy_r    <= 1'b1;
    end else begin
      case (state)
        ST_SWEEP: begin
          sweep_cnt <= sweep_cnt + IW'(1);
          if (sweep_cnt == IW'(N - 1)) begin
            state  <= ST_RUN;
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          state  <= ST_RUN;
          busy_r <= 1'b0;
        end
        default: begin
          state     <= ST_SWEEP;
          sweep_cnt <= {IW{1'b0}};
          busy_r    <= 1'b1;
        end
      endcase
    end
  end

  // Command pipeline and registered outputs; reset clears every valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld    <= 1'b0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s3_vld    <= 1'b0;
      s4_wr     <= 1'b0;
      rsp_vld_r <= 1'b0;
      evt_vld_r <= 1'b0;
    end else begin
      s0_vld    <= cmd_vld & ~busy_r;
      s0_uc.op  <= op_t'(cmd_op);
      s0_uc.id  <= cmd_id;
      s0_uc.dat <= cmd_dat;

      s1_vld    <= s0_vld;
      s1_uc     <= s0_uc;

      s2_vld    <= s1_vld;
      s2_uc     <= s1_uc;
      s2_opv    <= s1_fwd;

      s3_vld    <= s2_vld;
      s3_op     <= s2_uc.op;
      s3_id     <= s2_uc.id;
      s3_opv    <= s2_opv_f;
      s3_res    <= alu_res;
      s3_ovf    <= alu_ovf;

      s4_wr     <= s3_wr;
      s4_id     <= s3_id;
      s4_res    <= s3_res;

      // Responses carry the pre-operation value (QRY: current, FADD: old).
      rsp_vld_r <= s3_vld & s3_attr[OP_OUTPUT_B];
      rsp_id_r  <= s3_id;
      rsp_dat_r <= s3_opv;
      evt_vld_r <= s3_vld & s3_ovf;
      evt_id_r  <= s3_id;
    end
  end

endmodule

// File: tb/tb_multi_counter_sram.sv
// Directed bench: one wrapping and one saturating instance (N=8, W=8) share
// the same stimulus; expected responses are queued with their due cycle and
// checked every cycle, including the absence of unexpected pulses.
module tb_multi_counter_sram;
  import multi_counter_sram_pkg::*;

  localparam int W = 8;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_vld;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_id;
  logic [W-1:0] cmd_dat;

  logic         rdy0, busy0, rsp_vld0, evt_vld0;
  logic [2:0]   rsp_id0, evt_id0;
  logic [W-1:0] rsp_dat0;
  logic         rdy1, busy1, rsp_vld1, evt_vld1;
  logic [2:0]   rsp_id1, evt_id1;
  logic [W-1:0] rsp_dat1;

  multi_counter_sram #(.W(W), .N(N), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(rdy0), .cmd_op(cmd_op),
    .cmd_id(cmd_id), .cmd_dat(cmd_dat), .busy_r(busy0), .rsp_vld_r(rsp_vld0),
    .rsp_id_r(rsp_id0), .rsp_dat_r(rsp_dat0), .evt_vld_r(evt_vld0), .evt_id_r(evt_id0)
  );

  multi_counter_sram #(.W(W), .N(N), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(rdy1), .cmd_op(cmd_op),
    .cmd_id(cmd_id), .cmd_dat(cmd_dat), .busy_r(busy1), .rsp_vld_r(rsp_vld1),
    .rsp_id_r(rsp_id1), .rsp_dat_r(rsp_dat1), .evt_vld_r(evt_vld1), .evt_id_r(evt_id1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op;
    int         id;
    int         dat;
    bit         rsp;
    int         d0;
    int         d1;
    bit         e0;
    bit         e1;
  } vec_t;

  typedef struct {
    int cyc;
    bit rsp;
    int id;
    int d0;
    int d1;
    bit e0;
    bit e1;
  } exp_t;

  vec_t tbl[$];
  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   n;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask

  // Compare outputs against the expectation due this cycle (or against idle).
  task automatic monitor();
    exp_t e;
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      check("rsp_vld0", 64'(rsp_vld0), 64'(e.rsp));
      check("rsp_vld1", 64'(rsp_vld1), 64'(e.rsp));
      if (e.rsp) begin
        check("rsp_id0", 64'(rsp_id0), 64'(e.id));
        check("rsp_dat0", 64'(rsp_dat0), 64'(e.d0));
        check("rsp_id1", 64'(rsp_id1), 64'(e.id));
        check("rsp_dat1", 64'(rsp_dat1), 64'(e.d1));
      end
      check("evt_vld0", 64'(evt_vld0), 64'(e.e0));
      check("evt_vld1", 64'(evt_vld1), 64'(e.e1));
      if (e.e0) check("evt_id0", 64'(evt_id0), 64'(e.id));
      if (e.e1) check("evt_id1", 64'(evt_id1), 64'(e.id));
    end else begin
      check("idle0", {62'd0, rsp_vld0, evt_vld0}, 64'd0);
      check("idle1", {62'd0, rsp_vld1, evt_vld1}, 64'd0);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [2:0] op, int id, int dat, bit rsp, int d0, int d1, bit e0, bit e1);
    exp_t e;
    cmd_vld = 1'b1;
    cmd_op  = op;
    cmd_id  = 3'(id);
    cmd_dat = 8'(dat);
    if (rsp || e0 || e1) begin
      e.cyc = cyc + 5;
      e.rsp = rsp; e.id = id; e.d0 = d0; e.d1 = d1; e.e0 = e0; e.e1 = e1;
      expq.push_back(e);
    end
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Count busy cycles from the current point (just after a reset edge).
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy0 && cnt < 50) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_op = 3'd0; cmd_id = 3'd0; cmd_dat = 8'd0;

    // Vector table: back-to-back commands, expected values for SAT=0 / SAT=1.
    for (int i = 0; i < N; i++) tbl.push_back('{OP_QRY, i, 0, 1'b1, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_INIT, 3, 10, 1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_ADD,  3, 5,  1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_SUB,  3, 2,  1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_FADD, 3, 1,  1'b1, 13, 13, 1'b0, 1'b0});
    tbl.push_back('{OP_QRY,  3, 0,  1'b1, 14, 14, 1'b0, 1'b0});
    tbl.push_back('{OP_INIT, 1, 250, 1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_ADD,  1, 10,  1'b0, 0, 0, 1'b1, 1'b1});
    tbl.push_back('{OP_QRY,  1, 0,   1'b1, 4, 255, 1'b0, 1'b0});
    tbl.push_back('{OP_INIT, 2, 3,   1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_SUB,  2, 5,   1'b0, 0, 0, 1'b1, 1'b1});
    tbl.push_back('{OP_QRY,  2, 0,   1'b1, 254, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_FADD, 1, 1,   1'b1, 4, 255, 1'b0, 1'b1});
    tbl.push_back('{OP_QRY,  1, 0,   1'b1, 5, 255, 1'b0, 1'b0});
    tbl.push_back('{OP_SUB,  2, 1,   1'b0, 0, 0, 1'b0, 1'b1});
    tbl.push_back('{OP_QRY,  2, 0,   1'b1, 253, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_NOP,  3, 99,  1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_QRY,  3, 0,   1'b1, 14, 14, 1'b0, 1'b0});
    tbl.push_back('{OP_INIT, 0, 255, 1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{OP_ADD,  0, 1,   1'b0, 0, 0, 1'b1, 1'b1});
    tbl.push_back('{OP_FADD, 0, 0,   1'b1, 0, 255, 1'b0, 1'b0});

    // Reset for two cycles, then check reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_busy0", 64'(busy0), 64'd1);
    check("rst_busy1", 64'(busy1), 64'd1);
    check("rst_rdy0", 64'(rdy0), 64'd0);
    check("rst_rsp0", 64'(rsp_vld0), 64'd0);
    check("rst_evt0", 64'(evt_vld0), 64'd0);
    mon_en = 1'b1;
    rst = 1'b0;

    // Sweep: INIT id0=77 held valid throughout must be dropped.
    cmd_vld = 1'b1; cmd_op = OP_INIT; cmd_id = 3'd0; cmd_dat = 8'd77;
    count_busy(n);
    cmd_vld = 1'b0;
    check("sweep_len", 64'(n), 64'd8);
    check("rdy_after", 64'(rdy0), 64'd1);

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].id, tbl[i].dat, tbl[i].rsp, tbl[i].d0, tbl[i].d1,
            tbl[i].e0, tbl[i].e1);
    end

    // Same-id dependencies at spacings 2, 3, 4 and 5.
    issue(OP_INIT, 5, 100, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(1);
    issue(OP_ADD, 5, 1, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(2);
    issue(OP_ADD, 5, 2, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);
    issue(OP_SUB, 5, 3, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(4);
    issue(OP_FADD, 5, 7, 1'b1, 100, 100, 1'b0, 1'b0);
    issue(OP_QRY, 5, 0, 1'b1, 107, 107, 1'b0, 1'b0);
    idle(8);
    check("drain1", 64'(expq.size()), 64'd0);

    // Mid-flight reset: the QRY must never respond.
    issue(OP_INIT, 6, 55, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(6);
    issue(OP_QRY, 4, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_busy", 64'(busy0), 64'd1);
    count_busy(n);
    check("resweep_len", 64'(n), 64'd8);

    // Reset partway through a sweep restarts it from address 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    check("part_sweep_len", 64'(n), 64'd8);

    issue(OP_QRY, 6, 0, 1'b1, 0, 0, 1'b0, 1'b0);
    issue(OP_QRY, 4, 0, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(8);
    check("drain2", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
